// File: rtl/wb_rr_xbar_if.sv
// ----------------------------------------------------------------------------
// wb_rr_xbar_if
// Bundles every Wishbone signal around the round-robin crossbar: the NM
// master-side request/response vectors, the NS slave-side strobes, the
// shared slave request fields, and the one-hot grant vector.
//
// Modports
//   slave  : view of the crossbar itself (it is the slave of the bus masters
//            and drives the slave-side request fields).
//   master : view of the environment around the crossbar (the bus masters
//            and the slave devices), the exact mirror of `slave`.
//
// Signals
//   m_cyc_i/m_stb_i/m_we_i [NM]       per-master cycle, strobe, write enable
//   m_addr_i [NM*AW]                   per-master address
//   m_wdata_i [NM*DW]                  per-master write data
//   m_sel_i [NM*DW/8]                  per-master byte select
//   m_rdata_o [NM*DW]                  per-master read data
//   m_ack_o/m_err_o [NM]               per-master acknowledge / error
//   s_cyc_o/s_stb_o [NS]               per-slave cycle / strobe (one-hot or 0)
//   s_we_o, s_addr_o, s_wdata_o,
//   s_sel_o                            shared slave request fields
//   s_rdata_i [NS*DW], s_ack_i [NS]    per-slave read data / acknowledge
//   gnt_o [NM]                         one-hot granted master, 0 when idle
// ----------------------------------------------------------------------------
interface wb_rr_xbar_if #(
    parameter int NM = 3,
    parameter int NS = 5,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [NM-1:0]      m_cyc_i;
    logic [NM-1:0]      m_stb_i;
    logic [NM-1:0]      m_we_i;
    logic [NM*AW-1:0]   m_addr_i;
    logic [NM*DW-1:0]   m_wdata_i;
    logic [NM*DW/8-1:0] m_sel_i;
    logic [NM*DW-1:0]   m_rdata_o;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_err_o;

    logic [NS-1:0]      s_cyc_o;
    logic [NS-1:0]      s_stb_o;
    logic               s_we_o;
    logic [AW-1:0]      s_addr_o;
    logic [DW-1:0]      s_wdata_o;
    logic [DW/8-1:0]    s_sel_o;
    logic [NS*DW-1:0]   s_rdata_i;
    logic [NS-1:0]      s_ack_i;

    logic [NM-1:0]      gnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_wdata_i, m_sel_i,
        output m_rdata_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
        input  s_rdata_i, s_ack_i,
        output gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_wdata_i, m_sel_i,
        input  m_rdata_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
        output s_rdata_i, s_ack_i,
        input  gnt_o
    );
endinterface

// File: rtl/wb_rr_xbar.sv
// ----------------------------------------------------------------------------
// wb_rr_xbar
// Round-robin Wishbone crossbar: NM masters share one slave-side path to NS
// address-decoded slaves. One transaction is in flight at a time. A winner is
// registered in IDLE, the granted master's request is forwarded live during
// BUSY, and the result (ack with read data, or error) is returned for exactly
// one cycle in RESP.
//
// Ports
//   clk  : sole clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : wb_rr_xbar_if.slave, all master/slave bus signals and gnt_o
//
// Parameters
//   NM, NS     : number of masters / slaves (1..8)
//   AW, DW     : address / data width (DW a multiple of 8)
//   SLV_BASE   : slave i base address in [i*AW +: AW]
//   SLV_MASK   : slave i address-compare mask in [i*AW +: AW]
//   TMO        : BUSY cycles allowed before a missing ack becomes an error
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; arbitrate among pending requests
// BUSY  | granted master's request presented to the decoded slave
// RESP  | one-cycle ack or error returned to the granted master
// ----------------------------------------------------------------------------
module wb_rr_xbar #(
    parameter int                NM       = 3,
    parameter int                NS       = 5,
    parameter int                AW       = 32,
    parameter int                DW       = 32,
    parameter logic [NS*AW-1:0]  SLV_BASE = {32'h4000_0000, 32'h3000_0000,
                                             32'h2000_0000, 32'h1000_0000,
                                             32'h0000_0000},
    parameter logic [NS*AW-1:0]  SLV_MASK = {5{32'hF000_0000}},
    parameter int                TMO      = 255
) (
    input  logic          clk,
    input  logic          rst,
    wb_rr_xbar_if.slave   bus
);

    localparam int MIW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
    localparam int SW  = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [MIW-1:0]  r_gnt;
    logic [MIW-1:0]  r_last;
    logic [15:0]     r_cnt;
    logic            r_err;
    logic [DW-1:0]   r_rdata;

    logic [NM-1:0]   w_req;
    logic            w_any_req;
    logic [MIW-1:0]  w_win;
    int              w_idx;

    logic            w_gm_cyc;
    logic            w_gm_we;
    logic [AW-1:0]   w_gm_addr;
    logic [DW-1:0]   w_gm_wdata;
    logic [SW-1:0]   w_gm_sel;

    logic            w_hit;
    logic [SIW-1:0]  w_sidx;
    logic            w_sel_ack;
    logic            w_tmo;

    assign w_req     = bus.m_cyc_i & bus.m_stb_i;
    assign w_any_req = |w_req;

    // Search starts just after the last granted master; iterating from the
    // far end backwards lets the closest requester overwrite earlier picks.
    always_comb begin
        w_win = r_last;
        w_idx = 0;
        for (int k = NM; k >= 1; k--) begin
            w_idx = (int'(r_last) + k) % NM;
            if (|(w_req & (NM'(1) << w_idx))) begin
                w_win = MIW'(w_idx);
            end
        end
    end

    // Granted master's request fields, taken live every cycle.
    assign w_gm_cyc   = |(bus.m_cyc_i & (NM'(1) << r_gnt));
    assign w_gm_we    = |(bus.m_we_i  & (NM'(1) << r_gnt));
    assign w_gm_addr  = AW'(bus.m_addr_i  >> (int'(r_gnt) * AW));
    assign w_gm_wdata = DW'(bus.m_wdata_i >> (int'(r_gnt) * DW));
    assign w_gm_sel   = SW'(bus.m_sel_i   >> (int'(r_gnt) * SW));

    // Address decode; descending loop so the lowest-indexed hit wins.
    always_comb begin
        w_hit  = 1'b0;
        w_sidx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((w_gm_addr & SLV_MASK[i*AW +: AW]) ==
                (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
                w_hit  = 1'b1;
                w_sidx = SIW'(i);
            end
        end
    end

    assign w_sel_ack = w_hit & |(bus.s_ack_i & (NS'(1) << w_sidx));
    // Counter holds the number of completed BUSY cycles, so the TMO-th
    // BUSY cycle is the one where it still reads TMO-1.
    assign w_tmo     = (r_cnt == 16'(TMO - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack takes priority over both abort and timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_sel_ack) begin
                    w_state_nxt = S_RESP;
                end else if (!w_gm_cyc) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_hit || w_tmo) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt   <= '0;
            r_last  <= MIW'(NM - 1);
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt <= w_win;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_sel_ack) begin
                        r_err   <= 1'b0;
                        r_rdata <= DW'(bus.s_rdata_i >> (int'(w_sidx) * DW));
                    end else if (!w_gm_cyc) begin
                        r_last  <= r_gnt;
                    end else if (!w_hit || w_tmo) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_RESP: begin
                    r_last <= r_gnt;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from registered state, so a reset edge forces them all
    // to zero in the same cycle.
    always_comb begin
        bus.s_cyc_o   = '0;
        bus.s_stb_o   = '0;
        bus.s_we_o    = 1'b0;
        bus.s_addr_o  = '0;
        bus.s_wdata_o = '0;
        bus.s_sel_o   = '0;
        bus.gnt_o     = '0;
        bus.m_ack_o   = '0;
        bus.m_err_o   = '0;
        bus.m_rdata_o = '0;

        if (r_state != S_IDLE) begin
            bus.gnt_o = NM'(1) << r_gnt;
        end

        if (r_state == S_BUSY) begin
            bus.s_we_o    = w_gm_we;
            bus.s_addr_o  = w_gm_addr;
            bus.s_wdata_o = w_gm_wdata;
            bus.s_sel_o   = w_gm_sel;
            if (w_hit) begin
                bus.s_cyc_o = NS'(1) << w_sidx;
                bus.s_stb_o = NS'(1) << w_sidx;
            end
        end

        if (r_state == S_RESP) begin
            if (r_err) begin
                bus.m_err_o = NM'(1) << r_gnt;
            end else begin
                bus.m_ack_o   = NM'(1) << r_gnt;
                bus.m_rdata_o = (NM*DW)'(r_rdata) << (int'(r_gnt) * DW);
            end
        end
    end

endmodule

// File: tb/tb_wb_rr_xbar.sv
module tb_wb_rr_xbar;

    localparam int NM = 3;
    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    wb_rr_xbar_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) ifc ();

    wb_rr_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .TMO(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW/8-1:0] sel);
        ifc.m_cyc_i[m]              = cyc;
        ifc.m_stb_i[m]              = cyc;
        ifc.m_we_i[m]               = we;
        ifc.m_addr_i[m*AW +: AW]    = addr;
        ifc.m_wdata_i[m*DW +: DW]   = wdata;
        ifc.m_sel_i[m*DW/8 +: DW/8] = sel;
    endtask

    task automatic drop_all();
        ifc.m_cyc_i = '0;
        ifc.m_stb_i = '0;
        ifc.m_we_i  = '0;
        ifc.s_ack_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drop_all();
        ifc.m_addr_i  = '0;
        ifc.m_wdata_i = '0;
        ifc.m_sel_i   = '0;
        ifc.s_rdata_i = '0;
        set_m(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'hF);
        tick();
        tick();
        n_checks++; if (ifc.gnt_o !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=000", ifc.gnt_o); end
        n_checks++; if (ifc.s_stb_o !== 5'b00000) begin n_fail++; $display("FAIL reset_stb got=%b exp=00000", ifc.s_stb_o); end
        n_checks++; if ((ifc.m_ack_o | ifc.m_err_o) !== 3'b000) begin n_fail++; $display("FAIL reset_ackerr got=%b/%b exp=000", ifc.m_ack_o, ifc.m_err_o); end
        drop_all();
        rst = 1'b1;
        tick();
        n_checks++; if (ifc.gnt_o !== 3'b000) begin n_fail++; $display("FAIL reset_idle_gnt got=%b exp=000", ifc.gnt_o); end
    endtask

    task automatic test_contention();
        logic [NM-1:0] exp_ord [4];
        logic [NM-1:0] got_ord [4];
        logic [NM-1:0] prev_gnt;
        logic [NM*DW-1:0] exp_rd;
        logic [DW-1:0] sdat;
        int ngr;
        int phase;
        bit done;
        exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100; exp_ord[3] = 3'b001;
        for (int i = 0; i < 4; i++) got_ord[i] = '0;
        for (int s = 0; s < NS; s++) ifc.s_rdata_i[s*DW +: DW] = 32'hA000_0000 + 32'(s);
        ifc.s_ack_i = 5'b11111;
        set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b1, 32'h1000_0200, 32'hDEAD_BEEF, 4'b0011);
        set_m(2, 1'b1, 1'b0, 32'h3000_0300, 32'h0, 4'hF);
        prev_gnt = '0;
        ngr = 0;
        phase = 0;
        done = 0;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            tick();
            n_checks++; if (!$onehot0(ifc.gnt_o)) begin n_fail++; $display("FAIL cont_onehot got=%b", ifc.gnt_o); end
            if (phase == 1) begin
                // RESP cycle of the transaction granted one cycle earlier
                sdat = (exp_ord[ngr-1] == 3'b001) ? 32'hA000_0000 :
                       (exp_ord[ngr-1] == 3'b010) ? 32'hA000_0001 : 32'hA000_0003;
                exp_rd = '0;
                for (int m = 0; m < NM; m++) if (exp_ord[ngr-1][m]) exp_rd[m*DW +: DW] = sdat;
                n_checks++; if (ifc.m_ack_o !== exp_ord[ngr-1]) begin n_fail++; $display("FAIL cont_ack got=%b exp=%b", ifc.m_ack_o, exp_ord[ngr-1]); end
                n_checks++; if (ifc.m_rdata_o !== exp_rd) begin n_fail++; $display("FAIL cont_rdata got=%h exp=%h", ifc.m_rdata_o, exp_rd); end
                phase = 0;
                if (ngr == 4) begin
                    drop_all();
                    done = 1;
                end
            end else if (ifc.gnt_o !== 3'b000 && prev_gnt === 3'b000) begin
                if (ngr < 4) got_ord[ngr] = ifc.gnt_o;
                ngr++;
                phase = 1;
                if (ifc.gnt_o === 3'b010) begin
                    n_checks++; if (ifc.s_addr_o !== 32'h1000_0200 || ifc.s_we_o !== 1'b1 || ifc.s_wdata_o !== 32'hDEAD_BEEF || ifc.s_sel_o !== 4'b0011) begin
                        n_fail++; $display("FAIL cont_fields got=%h/%b/%h/%b exp=10000200/1/deadbeef/0011", ifc.s_addr_o, ifc.s_we_o, ifc.s_wdata_o, ifc.s_sel_o);
                    end
                end
            end else begin
                n_checks++; if (ifc.m_rdata_o !== '0) begin n_fail++; $display("FAIL cont_rdata_idle got=%h exp=0", ifc.m_rdata_o); end
            end
            prev_gnt = ifc.gnt_o;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL cont_timeout got=%0d grants exp=4", ngr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_ord[i] !== exp_ord[i]) begin n_fail++; $display("FAIL cont_order[%0d] got=%b exp=%b", i, got_ord[i], exp_ord[i]); end
        end
        drop_all();
        tick();
    endtask

    task automatic test_single_read();
        set_m(0, 1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF);
        tick();
        n_checks++; if (ifc.s_stb_o !== 5'b00100 || ifc.s_cyc_o !== 5'b00100) begin n_fail++; $display("FAIL rd_stb got=%b/%b exp=00100", ifc.s_stb_o, ifc.s_cyc_o); end
        n_checks++; if (ifc.gnt_o !== 3'b001) begin n_fail++; $display("FAIL rd_gnt got=%b exp=001", ifc.gnt_o); end
        n_checks++; if (ifc.s_addr_o !== 32'h2000_0010 || ifc.s_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_addr got=%h/%b exp=20000010/0", ifc.s_addr_o, ifc.s_we_o); end
        ifc.s_ack_i[3] = 1'b1;
        ifc.s_rdata_i[3*DW +: DW] = 32'hBAD0_0000;
        tick();
        n_checks++; if (ifc.m_ack_o !== 3'b000 || ifc.s_stb_o !== 5'b00100) begin n_fail++; $display("FAIL rd_foreign_ack got=%b/%b exp=000/00100", ifc.m_ack_o, ifc.s_stb_o); end
        ifc.s_ack_i = '0;
        tick();
        n_checks++; if (ifc.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL rd_busy3_ack got=%b exp=000", ifc.m_ack_o); end
        ifc.s_ack_i[2] = 1'b1;
        ifc.s_rdata_i[2*DW +: DW] = 32'h1234_5678;
        tick();
        n_checks++; if (ifc.m_ack_o !== 3'b001) begin n_fail++; $display("FAIL rd_ack got=%b exp=001", ifc.m_ack_o); end
        n_checks++; if (ifc.m_rdata_o !== 96'h0000_0000_0000_0000_1234_5678) begin n_fail++; $display("FAIL rd_data got=%h exp=12345678 in slice 0", ifc.m_rdata_o); end
        n_checks++; if (ifc.s_stb_o !== 5'b00000) begin n_fail++; $display("FAIL rd_resp_stb got=%b exp=00000", ifc.s_stb_o); end
        drop_all();
        tick();
        n_checks++; if (ifc.m_ack_o !== 3'b000 || ifc.gnt_o !== 3'b000) begin n_fail++; $display("FAIL rd_end got=%b/%b exp=000/000", ifc.m_ack_o, ifc.gnt_o); end
    endtask

    task automatic test_unmapped();
        for (int s = 0; s < NS; s++) ifc.s_rdata_i[s*DW +: DW] = 32'hFFFF_FFFF;
        set_m(1, 1'b1, 1'b1, 32'h8000_0040, 32'h55AA_55AA, 4'hF);
        tick();
        n_checks++; if (ifc.s_stb_o !== 5'b00000 || ifc.s_cyc_o !== 5'b00000) begin n_fail++; $display("FAIL um_stb got=%b/%b exp=00000", ifc.s_stb_o, ifc.s_cyc_o); end
        n_checks++; if (ifc.gnt_o !== 3'b010) begin n_fail++; $display("FAIL um_gnt got=%b exp=010", ifc.gnt_o); end
        tick();
        n_checks++; if (ifc.m_err_o !== 3'b010 || ifc.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL um_err got=%b/%b exp=010/000", ifc.m_err_o, ifc.m_ack_o); end
        n_checks++; if (ifc.m_rdata_o !== '0) begin n_fail++; $display("FAIL um_rdata got=%h exp=0", ifc.m_rdata_o); end
        drop_all();
        tick();
        n_checks++; if (ifc.m_err_o !== 3'b000) begin n_fail++; $display("FAIL um_end got=%b exp=000", ifc.m_err_o); end
    endtask

    task automatic test_timeout();
        set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
        for (int b = 1; b <= 4; b++) begin
            tick();
            n_checks++; if (ifc.m_err_o !== 3'b000 || ifc.s_stb_o !== 5'b00010) begin n_fail++; $display("FAIL tmo_busy%0d got=%b/%b exp=000/00010", b, ifc.m_err_o, ifc.s_stb_o); end
        end
        tick();
        n_checks++; if (ifc.m_err_o !== 3'b001 || ifc.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL tmo_err got=%b/%b exp=001/000", ifc.m_err_o, ifc.m_ack_o); end
        n_checks++; if (ifc.m_rdata_o !== '0) begin n_fail++; $display("FAIL tmo_rdata got=%h exp=0", ifc.m_rdata_o); end
        drop_all();
        tick();
        // ack in the terminal-count cycle must win over the timeout
        set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
        tick(); tick(); tick();
        n_checks++; if (ifc.m_err_o !== 3'b000 || ifc.gnt_o !== 3'b001) begin n_fail++; $display("FAIL tmo2_busy3 got=%b/%b exp=000/001", ifc.m_err_o, ifc.gnt_o); end
        tick();
        ifc.s_ack_i[1] = 1'b1;
        ifc.s_rdata_i[1*DW +: DW] = 32'hCAFE_F00D;
        tick();
        n_checks++; if (ifc.m_ack_o !== 3'b001 || ifc.m_err_o !== 3'b000) begin n_fail++; $display("FAIL tmo2_ack got=%b/%b exp=001/000", ifc.m_ack_o, ifc.m_err_o); end
        n_checks++; if (ifc.m_rdata_o[31:0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL tmo2_rdata got=%h exp=cafef00d", ifc.m_rdata_o[31:0]); end
        drop_all();
        tick();
    endtask

    task automatic test_abort();
        set_m(2, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
        tick();
        n_checks++; if (ifc.s_stb_o !== 5'b01000 || ifc.gnt_o !== 3'b100) begin n_fail++; $display("FAIL ab_busy got=%b/%b exp=01000/100", ifc.s_stb_o, ifc.gnt_o); end
        ifc.m_cyc_i[2] = 1'b0;
        tick();
        n_checks++; if (ifc.s_stb_o !== 5'b00000 || ifc.gnt_o !== 3'b000) begin n_fail++; $display("FAIL ab_drop got=%b/%b exp=00000/000", ifc.s_stb_o, ifc.gnt_o); end
        n_checks++; if ((ifc.m_ack_o | ifc.m_err_o) !== 3'b000) begin n_fail++; $display("FAIL ab_noresp got=%b/%b exp=000", ifc.m_ack_o, ifc.m_err_o); end
        drop_all();
        set_m(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
        tick();
        n_checks++; if (ifc.gnt_o !== 3'b001) begin n_fail++; $display("FAIL ab_next_gnt got=%b exp=001", ifc.gnt_o); end
        ifc.s_ack_i[0] = 1'b1;
        tick();
        n_checks++; if (ifc.m_ack_o !== 3'b001) begin n_fail++; $display("FAIL ab_next_ack got=%b exp=001", ifc.m_ack_o); end
        drop_all();
        tick();
    endtask

    task automatic test_midop_reset();
        set_m(1, 1'b1, 1'b1, 32'h1000_0000, 32'h1111_2222, 4'hF);
        tick();
        n_checks++; if (ifc.gnt_o !== 3'b010) begin n_fail++; $display("FAIL mr_busy got=%b exp=010", ifc.gnt_o); end
        rst = 1'b0;
        tick();
        n_checks++; if (ifc.gnt_o !== 3'b000 || ifc.s_stb_o !== 5'b00000 || ifc.s_cyc_o !== 5'b00000) begin n_fail++; $display("FAIL mr_strobes got=%b/%b/%b exp=0", ifc.gnt_o, ifc.s_stb_o, ifc.s_cyc_o); end
        n_checks++; if (ifc.s_addr_o !== '0 || ifc.s_we_o !== 1'b0 || ifc.s_wdata_o !== '0 || ifc.s_sel_o !== '0) begin n_fail++; $display("FAIL mr_fields got=%h/%b/%h/%b exp=0", ifc.s_addr_o, ifc.s_we_o, ifc.s_wdata_o, ifc.s_sel_o); end
        n_checks++; if ((ifc.m_ack_o | ifc.m_err_o) !== 3'b000 || ifc.m_rdata_o !== '0) begin n_fail++; $display("FAIL mr_resp got=%b/%b/%h exp=0", ifc.m_ack_o, ifc.m_err_o, ifc.m_rdata_o); end
        set_m(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
        tick();
        n_checks++; if (ifc.gnt_o !== 3'b000) begin n_fail++; $display("FAIL mr_held got=%b exp=000", ifc.gnt_o); end
        rst = 1'b1;
        tick();
        n_checks++; if (ifc.gnt_o !== 3'b001) begin n_fail++; $display("FAIL mr_first got=%b exp=001", ifc.gnt_o); end
        ifc.s_ack_i[0] = 1'b1;
        tick();
        n_checks++; if (ifc.m_ack_o !== 3'b001) begin n_fail++; $display("FAIL mr_ack got=%b exp=001", ifc.m_ack_o); end
        drop_all();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_contention();
        test_single_read();
        test_unmapped();
        test_timeout();
        test_abort();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
